// File: rtl/complex_divider.sv
// Sequential complex divider q = (a + jb) / (c + jd) with one shared signed multiplier
// and two parallel radix-2 restoring dividers, valid/ready on both sides.
module complex_divider #(
    parameter int unsigned W    = 16,
    parameter int unsigned FRAC = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] input1,
    input  logic [W-1:0] input2,
    input  logic [W-1:0] input3,
    input  logic [W-1:0] input4,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] q_re,
    output logic [W-1:0] q_im,
    output logic         div_by_zero,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         busy
);

    localparam int unsigned PW   = 2 * W;
    localparam int unsigned NW   = 2 * W + 2;
    localparam int unsigned DN   = 2 * W + 1 + FRAC;
    localparam int unsigned CW   = $clog2(DN + 1);
    localparam int unsigned NMUL = 6;

    localparam logic [DN-1:0] POS_MAX = DN'((2 ** (W - 1)) - 1);
    localparam logic [DN-1:0] NEG_MAG = DN'(2 ** (W - 1));

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_SAT,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    logic signed [W-1:0]  op_a, op_b, op_c, op_d;
    logic signed [NW-1:0] num_re, num_im;
    logic        [NW-1:0] den;
    logic        [CW-1:0] cnt;
    logic        [NW-1:0] rem_re, rem_im;
    logic        [DN-1:0] sh_re, sh_im;
    logic                 neg_re, neg_im;

    logic signed [W-1:0]  mul_x, mul_y;
    logic signed [PW-1:0] prod;
    logic        [NW-1:0] den_acc;
    logic        [NW-1:0] mag_re, mag_im;
    logic [NW+DN-1:0]     step_re, step_im;

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    function automatic logic [NW+DN-1:0] div_step(input logic [NW-1:0] rem,
                                                  input logic [DN-1:0] sh,
                                                  input logic [NW-1:0] dv);
        logic [NW-1:0] trial;
        logic [NW:0]   diff;
        trial = {rem[NW-2:0], sh[DN-1]};
        diff  = {1'b0, trial} - {1'b0, dv};
        if (diff[NW]) begin
            return {trial, sh[DN-2:0], 1'b0};
        end
        return {diff[NW-1:0], sh[DN-2:0], 1'b1};
    endfunction

    // Apply sign to the quotient magnitude and clamp to the W-bit signed range.
    function automatic logic [W-1:0] saturate(input logic [DN-1:0] mag, input logic neg);
        logic [DN-1:0] negv;
        if (!neg) begin
            return (mag > POS_MAX) ? W'(POS_MAX) : W'(mag);
        end
        negv = DN'(0) - mag;
        return (mag > NEG_MAG) ? W'(NEG_MAG) : W'(negv);
    endfunction

    // Shared multiplier operand select: ac, bd, bc, ad, cc, dd.
    always_comb begin
        mul_x = op_c;
        mul_y = op_c;
        case (cnt)
            CW'(0):  begin mul_x = op_a; mul_y = op_c; end
            CW'(1):  begin mul_x = op_b; mul_y = op_d; end
            CW'(2):  begin mul_x = op_b; mul_y = op_c; end
            CW'(3):  begin mul_x = op_a; mul_y = op_d; end
            CW'(4):  begin mul_x = op_c; mul_y = op_c; end
            default: begin mul_x = op_d; mul_y = op_d; end
        endcase
        prod    = PW'(mul_x) * PW'(mul_y);
        den_acc = den + NW'($unsigned(prod));
        mag_re  = num_re[NW-1] ? $unsigned(-num_re) : $unsigned(num_re);
        mag_im  = num_im[NW-1] ? $unsigned(-num_im) : $unsigned(num_im);
        step_re = div_step(rem_re, sh_re, den);
        step_im = div_step(rem_im, sh_im, den);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (in_valid && in_ready) state_nxt = S_MUL;
            S_MUL:  if (cnt == CW'(NMUL - 1)) state_nxt = (den_acc == '0) ? S_SAT : S_DIV;
            S_DIV:  if (cnt == CW'(DN - 1)) state_nxt = S_SAT;
            S_SAT:  state_nxt = S_DONE;
            S_DONE: if (out_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Datapath and registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a        <= '0;
            op_b        <= '0;
            op_c        <= '0;
            op_d        <= '0;
            num_re      <= '0;
            num_im      <= '0;
            den         <= '0;
            cnt         <= '0;
            rem_re      <= '0;
            rem_im      <= '0;
            sh_re       <= '0;
            sh_im       <= '0;
            neg_re      <= 1'b0;
            neg_im      <= 1'b0;
            q_re        <= '0;
            q_im        <= '0;
            div_by_zero <= 1'b0;
            in_ready    <= 1'b1;
            out_valid   <= 1'b0;
            busy        <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid && in_ready) begin
                        op_a   <= $signed(input1);
                        op_b   <= $signed(input2);
                        op_c   <= $signed(input3);
                        op_d   <= $signed(input4);
                        num_re <= '0;
                        num_im <= '0;
                        den    <= '0;
                        cnt    <= '0;
                    end
                end
                S_MUL: begin
                    cnt <= cnt + CW'(1);
                    case (cnt)
                        CW'(0), CW'(1): num_re <= num_re + NW'(prod);
                        CW'(2):         num_im <= num_im + NW'(prod);
                        CW'(3):         num_im <= num_im - NW'(prod);
                        CW'(4):         den    <= den_acc;
                        default: begin
                            den    <= den_acc;
                            cnt    <= '0;
                            rem_re <= '0;
                            rem_im <= '0;
                            sh_re  <= DN'(mag_re) << FRAC;
                            sh_im  <= DN'(mag_im) << FRAC;
                            neg_re <= num_re[NW-1];
                            neg_im <= num_im[NW-1];
                        end
                    endcase
                end
                S_DIV: begin
                    cnt                <= cnt + CW'(1);
                    {rem_re, sh_re}    <= step_re;
                    {rem_im, sh_im}    <= step_im;
                end
                S_SAT: begin
                    div_by_zero <= (den == '0);
                    q_re        <= (den == '0) ? '0 : saturate(sh_re, neg_re);
                    q_im        <= (den == '0) ? '0 : saturate(sh_im, neg_im);
                end
                default: ;
            endcase
            in_ready  <= (state_nxt == S_IDLE);
            out_valid <= (state_nxt == S_DONE);
            busy      <= (state_nxt != S_IDLE);
        end
    end

endmodule
